// File: rtl/reg_file_wr_ctrl_if.sv
// reg_file_wr_ctrl_if: requester handshakes, clear control and register-file write port
interface reg_file_wr_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              i_core_valid;
  logic [ADDR_W-1:0] i_core_addr;
  logic [DATA_W-1:0] i_core_dat;
  logic              o_core_ready;
  logic              i_dbg_valid;
  logic [ADDR_W-1:0] i_dbg_addr;
  logic [DATA_W-1:0] i_dbg_dat;
  logic              o_dbg_ready;
  logic              i_clr_req;
  logic              o_busy;
  logic              o_clr_done;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_dat;
  modport slave (
    input  i_core_valid, i_core_addr, i_core_dat, i_dbg_valid, i_dbg_addr, i_dbg_dat, i_clr_req,
    output o_core_ready, o_dbg_ready, o_busy, o_clr_done, o_wr_en, o_wr_addr, o_wr_dat
  );
  modport master (
    output i_core_valid, i_core_addr, i_core_dat, i_dbg_valid, i_dbg_addr, i_dbg_dat, i_clr_req,
    input  o_core_ready, o_dbg_ready, o_busy, o_clr_done, o_wr_en, o_wr_addr, o_wr_dat
  );
endinterface

// File: rtl/reg_file_wr_ctrl.sv
// reg_file_wr_ctrl: round-robin core/debug write arbiter with x01..x31 clear sequencer
module reg_file_wr_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst_n,
  reg_file_wr_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t state, state_nx;
  logic last_dbg, last_dbg_nx, wr_en_nx, idle, core_xfer, dbg_xfer;
  logic [ADDR_W-1:0] wr_addr_nx;
  logic [DATA_W-1:0] wr_dat_nx;
  // readies are gated by rst_n so they stay low while reset is held
  assign idle = rst_n && state == IDLE && !bus.i_clr_req;
  assign bus.o_core_ready = idle && bus.i_core_valid && (!bus.i_dbg_valid || last_dbg);
  assign bus.o_dbg_ready = idle && bus.i_dbg_valid && (!bus.i_core_valid || !last_dbg);
  assign core_xfer = bus.i_core_valid && bus.o_core_ready;
  assign dbg_xfer = bus.i_dbg_valid && bus.o_dbg_ready;
  assign bus.o_busy = state != IDLE;
  assign bus.o_clr_done = state == DONE;
  always_comb begin
    state_nx = state;
    last_dbg_nx = last_dbg;
    wr_en_nx = 1'b0;
    wr_addr_nx = bus.o_wr_addr;
    wr_dat_nx = bus.o_wr_dat;
    case (state)
      IDLE:
        if (bus.i_clr_req) begin
          state_nx = CLEAR;
          wr_en_nx = 1'b1;
          wr_addr_nx = ADDR_W'(1);
          wr_dat_nx = '0;
        end else if (core_xfer || dbg_xfer) begin
          last_dbg_nx = dbg_xfer;
          wr_addr_nx = dbg_xfer ? bus.i_dbg_addr : bus.i_core_addr;
          wr_dat_nx = dbg_xfer ? bus.i_dbg_dat : bus.i_core_dat;
          wr_en_nx = |wr_addr_nx;
        end
      CLEAR:
        if (bus.o_wr_addr == ADDR_W'(31)) state_nx = DONE;
        else begin
          wr_en_nx = 1'b1;
          wr_addr_nx = bus.o_wr_addr + ADDR_W'(1);
        end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_dbg <= 1'b1;
      bus.o_wr_en <= 1'b0;
      bus.o_wr_addr <= '0;
      bus.o_wr_dat <= '0;
    end else begin
      state <= state_nx;
      last_dbg <= last_dbg_nx;
      bus.o_wr_en <= wr_en_nx;
      bus.o_wr_addr <= wr_addr_nx;
      bus.o_wr_dat <= wr_dat_nx;
    end
  end
endmodule

// File: tb/tb_reg_file_wr_ctrl.sv
// tb_reg_file_wr_ctrl: directed checks of arbitration, write timing, clear sequence and reset abort
module tb_reg_file_wr_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_err = 0;
  int n_wr, n_done;
  reg_file_wr_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();
  reg_file_wr_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic cv, input logic [4:0] ca, input logic [31:0] cd,
                       input logic dv, input logic [4:0] da, input logic [31:0] dd);
    bus.i_core_valid = cv;
    bus.i_core_addr = ca;
    bus.i_core_dat = cd;
    bus.i_dbg_valid = dv;
    bus.i_dbg_addr = da;
    bus.i_dbg_dat = dd;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(bus.o_wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(bus.o_wr_addr), 0);
    chk({tag, "_wr_dat"}, bus.o_wr_dat, 0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 0);
    chk({tag, "_done"}, 32'(bus.o_clr_done), 0);
    chk({tag, "_core_rdy"}, 32'(bus.o_core_ready), 0);
    chk({tag, "_dbg_rdy"}, 32'(bus.o_dbg_ready), 0);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.i_clr_req = 1'b0;
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tie%0d_core_rdy", i), 32'(bus.o_core_ready), 32'(i % 2 == 0));
      chk($sformatf("tie%0d_dbg_rdy", i), 32'(bus.o_dbg_ready), 32'(i % 2 == 1));
      tick();
      chk($sformatf("tie%0d_wr_en", i), 32'(bus.o_wr_en), 1);
      chk($sformatf("tie%0d_wr_addr", i), 32'(bus.o_wr_addr), (i % 2 == 1) ? 7 : 3);
      chk($sformatf("tie%0d_wr_dat", i), bus.o_wr_dat, (i % 2 == 1) ? 32'h77 : 32'h33);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("idle_wr_en", 32'(bus.o_wr_en), 0);
    chk("idle_hold_addr", 32'(bus.o_wr_addr), 7);
    chk("idle_hold_dat", bus.o_wr_dat, 32'h77);
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    #1;
    chk("core_only_rdy", 32'(bus.o_core_ready), 1);
    chk("core_only_dbg_rdy", 32'(bus.o_dbg_ready), 0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("core_only_wr_en", 32'(bus.o_wr_en), 1);
    chk("core_only_wr_addr", 32'(bus.o_wr_addr), 5);
    chk("core_only_wr_dat", bus.o_wr_dat, 32'hDEADBEEF);
    tick();
    chk("core_only_after_en", 32'(bus.o_wr_en), 0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
    #1;
    chk("dbg_x0_rdy", 32'(bus.o_dbg_ready), 1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("dbg_x0_wr_en", 32'(bus.o_wr_en), 0);
    tick();
    // clear with both requesters waiting; debug was granted last, so core wins afterwards
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
    bus.i_clr_req = 1'b1;
    #1;
    chk("clr_T_core_rdy", 32'(bus.o_core_ready), 0);
    chk("clr_T_dbg_rdy", 32'(bus.o_dbg_ready), 0);
    tick();
    bus.i_clr_req = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      chk($sformatf("clr%0d_wr_en", k), 32'(bus.o_wr_en), 1);
      chk($sformatf("clr%0d_wr_addr", k), 32'(bus.o_wr_addr), 32'(k));
      chk($sformatf("clr%0d_wr_dat", k), bus.o_wr_dat, 0);
      chk($sformatf("clr%0d_busy", k), 32'(bus.o_busy), 1);
      chk($sformatf("clr%0d_done", k), 32'(bus.o_clr_done), 0);
      chk($sformatf("clr%0d_rdy", k), 32'({bus.o_core_ready, bus.o_dbg_ready}), 0);
      tick();
    end
    chk("clr32_wr_en", 32'(bus.o_wr_en), 0);
    chk("clr32_done", 32'(bus.o_clr_done), 1);
    chk("clr32_busy", 32'(bus.o_busy), 1);
    chk("clr32_rdy", 32'({bus.o_core_ready, bus.o_dbg_ready}), 0);
    tick();
    chk("clr33_done", 32'(bus.o_clr_done), 0);
    chk("clr33_busy", 32'(bus.o_busy), 0);
    chk("clr33_core_rdy", 32'(bus.o_core_ready), 1);
    chk("clr33_dbg_rdy", 32'(bus.o_dbg_ready), 0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("clr34_wr_addr", 32'(bus.o_wr_addr), 9);
    chk("clr34_wr_dat", bus.o_wr_dat, 32'h99);
    tick();
    bus.i_clr_req = 1'b1;
    tick();
    bus.i_clr_req = 1'b0;
    n_wr = 0;
    n_done = 0;
    for (int c = 1; c <= 40; c++) begin
      bus.i_clr_req = (c == 5);
      n_wr += int'(bus.o_wr_en);
      n_done += int'(bus.o_clr_done);
      tick();
    end
    bus.i_clr_req = 1'b0;
    chk("repulse_writes", 32'(n_wr), 31);
    chk("repulse_done", 32'(n_done), 1);
    chk("repulse_busy_end", 32'(bus.o_busy), 0);
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
    bus.i_clr_req = 1'b1;
    tick();
    bus.i_clr_req = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    chk("abort_T10_addr", 32'(bus.o_wr_addr), 10);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    tick();
    chk("abort_held_done", 32'(bus.o_clr_done), 0);
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("post_rst%0d_wr_en", c), 32'(bus.o_wr_en), 0);
      chk($sformatf("post_rst%0d_done", c), 32'(bus.o_clr_done), 0);
      chk($sformatf("post_rst%0d_busy", c), 32'(bus.o_busy), 0);
    end
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
    #1;
    chk("post_rst_tie_core", 32'(bus.o_core_ready), 1);
    chk("post_rst_tie_dbg", 32'(bus.o_dbg_ready), 0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("post_rst_wr_en", 32'(bus.o_wr_en), 1);
    chk("post_rst_wr_addr", 32'(bus.o_wr_addr), 3);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
